// File: rtl/irq_controller_if.sv
// Register bus between a hart-side master and the interrupt controller.
// Single-cycle request strobe; the slave acks exactly one cycle later.
interface irq_controller_if;
    logic        bus_req;
    logic        bus_we;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/irq_controller.sv
// Single-context PLIC-style interrupt controller.
// Per-source gateway (pending / in-service), programmable priority, enable mask and
// threshold, claim/complete over a word-addressed register bus, and a sequential
// one-source-per-cycle priority scan that commits a winner once per pass and drives
// a registered external interrupt line.
module irq_controller #(
    parameter int NSRC   = 32,
    parameter int PRIO_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC-1:0]     i_sources,
    irq_controller_if.slave     bus,
    output logic                o_ext_irq
);

    localparam int IDW = $clog2(NSRC);

    localparam logic [5:0]     ADDR_PEND  = 6'h20;
    localparam logic [5:0]     ADDR_EN    = 6'h21;
    localparam logic [5:0]     ADDR_THR   = 6'h22;
    localparam logic [5:0]     ADDR_CLAIM = 6'h23;
    localparam logic [5:0]     PRIO_END   = 6'(NSRC);
    localparam logic [IDW-1:0] LAST_IDX   = IDW'(NSRC - 1);

    // Configuration and gateway state
    logic [PRIO_W-1:0] r_prio [NSRC];
    logic [NSRC-1:0]   r_pending;
    logic [NSRC-1:0]   r_inservice;
    logic [NSRC-1:0]   r_enable;
    logic [PRIO_W-1:0] r_threshold;

    // Scan state
    logic [IDW-1:0]    r_scanIdx;
    logic [IDW-1:0]    r_curId;
    logic [PRIO_W-1:0] r_curPrio;
    logic [IDW-1:0]    r_bestId;
    logic [PRIO_W-1:0] r_bestPrio;
    logic              r_extIrq;

    // Bus response
    logic              r_ack;
    logic [31:0]       r_rdata;

    logic              w_rd;
    logic              w_wr;
    logic              w_isPrio;
    logic [IDW-1:0]    w_addrIdx;
    logic              w_claimOk;
    logic              w_claim;
    logic [IDW-1:0]    w_completeId;
    logic              w_complete;
    logic [31:0]       w_readData;
    logic [NSRC-1:0]   w_pendNext;
    logic [NSRC-1:0]   w_isvNext;
    logic              w_scanHit;
    logic [IDW-1:0]    w_runId;
    logic [PRIO_W-1:0] w_runPrio;

    // Decode the bus request and qualify claim / complete against live state
    always_comb begin
        w_rd         = bus.bus_req & ~bus.bus_we;
        w_wr         = bus.bus_req &  bus.bus_we;
        w_isPrio     = (bus.bus_addr < PRIO_END);
        w_addrIdx    = bus.bus_addr[IDW-1:0];
        w_claimOk    = (r_bestId != '0) && r_pending[r_bestId] && r_enable[r_bestId]
                       && (r_bestPrio > r_threshold);
        w_claim      = w_rd && (bus.bus_addr == ADDR_CLAIM) && w_claimOk;
        w_completeId = bus.bus_wdata[IDW-1:0];
        w_complete   = w_wr && (bus.bus_addr == ADDR_CLAIM) && (w_completeId != '0)
                       && r_inservice[w_completeId];
    end

    // Read data mux; a claim read returns 0 when the committed winner is no longer valid
    always_comb begin
        w_readData = '0;
        if (w_isPrio) begin
            w_readData[PRIO_W-1:0] = r_prio[w_addrIdx];
        end else begin
            case (bus.bus_addr)
                ADDR_PEND:  w_readData[NSRC-1:0]   = r_pending;
                ADDR_EN:    w_readData[NSRC-1:0]   = r_enable;
                ADDR_THR:   w_readData[PRIO_W-1:0] = r_threshold;
                ADDR_CLAIM: if (w_claimOk) w_readData[IDW-1:0] = r_bestId;
                default:    ;
            endcase
        end
    end

    // Gateway: a source pends only when idle; a claim beats a same-cycle set of that ID
    always_comb begin
        w_pendNext    = r_pending | (i_sources & ~r_pending & ~r_inservice);
        w_pendNext[0] = 1'b0;
        w_isvNext     = r_inservice;
        if (w_claim) begin
            w_pendNext[r_bestId] = 1'b0;
            w_isvNext[r_bestId]  = 1'b1;
        end
        if (w_complete) begin
            w_isvNext[w_completeId] = 1'b0;
        end
    end

    // Examine one source per cycle; strict compare keeps the lower ID on a tie
    always_comb begin
        w_scanHit = r_pending[r_scanIdx] && r_enable[r_scanIdx]
                    && (r_prio[r_scanIdx] > r_curPrio);
        w_runId   = w_scanHit ? r_scanIdx : r_curId;
        w_runPrio = w_scanHit ? r_prio[r_scanIdx] : r_curPrio;
    end

    // Register pending and in-service bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_inservice <= '0;
        end else begin
            r_pending   <= w_pendNext;
            r_inservice <= w_isvNext;
        end
    end

    // Software-writable configuration; priority 0 slot and enable bit 0 stay zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                r_prio[i] <= '0;
            end
            r_enable    <= '0;
            r_threshold <= '0;
        end else if (w_wr) begin
            if (w_isPrio) begin
                if (w_addrIdx != '0) begin
                    r_prio[w_addrIdx] <= bus.bus_wdata[PRIO_W-1:0];
                end
            end else if (bus.bus_addr == ADDR_EN) begin
                r_enable <= {bus.bus_wdata[NSRC-1:1], 1'b0};
            end else if (bus.bus_addr == ADDR_THR) begin
                r_threshold <= bus.bus_wdata[PRIO_W-1:0];
            end
        end
    end

    // Scan pointer, running candidate and per-pass commit; a claim overrides a same-cycle commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scanIdx  <= '0;
            r_curId    <= '0;
            r_curPrio  <= '0;
            r_bestId   <= '0;
            r_bestPrio <= '0;
            r_extIrq   <= 1'b0;
        end else begin
            if (r_scanIdx == LAST_IDX) begin
                r_scanIdx  <= '0;
                r_curId    <= '0;
                r_curPrio  <= '0;
                r_bestId   <= w_runId;
                r_bestPrio <= w_runPrio;
                r_extIrq   <= (w_runPrio > r_threshold);
            end else begin
                r_scanIdx  <= r_scanIdx + IDW'(1);
                r_curId    <= w_runId;
                r_curPrio  <= w_runPrio;
            end
            if (w_claim) begin
                r_bestId   <= '0;
                r_bestPrio <= '0;
                r_extIrq   <= 1'b0;
            end
        end
    end

    // Bus response: ack one cycle after every request, read data only for reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= bus.bus_req;
            r_rdata <= w_rd ? w_readData : '0;
        end
    end

    assign bus.bus_ack   = r_ack;
    assign bus.bus_rdata = r_rdata;
    assign o_ext_irq     = r_extIrq;

endmodule
